// File: rtl/ternary_pkg.sv
// Shared ternary definitions: trit encodings, multiplier FSM states and a
// trit validity helper.
package ternary_pkg;

  localparam logic [1:0] T0   = 2'b00;
  localparam logic [1:0] T1   = 2'b01;
  localparam logic [1:0] T2   = 2'b10;
  localparam logic [1:0] TINV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic trit_valid(input logic [1:0] t);
    return t != TINV;
  endfunction

endpackage

// File: rtl/ternary_full_adder.sv
// Ternary full adder: two trits plus a binary carry-in, trit sum and binary carry-out.
module ternary_full_adder
  import ternary_pkg::*;
(
  input  logic [1:0] x_i,
  input  logic [1:0] y_i,
  input  logic       cin_i,
  output logic [1:0] sum_c,
  output logic       cout_c
);

  logic [2:0] s;

  always_comb begin
    s = 3'(x_i) + 3'(y_i) + 3'(cin_i);
    if (s >= 3'd3) begin
      sum_c  = 2'(s - 3'd3);
      cout_c = 1'b1;
    end else begin
      sum_c  = s[1:0];
      cout_c = 1'b0;
    end
  end

endmodule

// File: rtl/ternary_multiplier.sv
// Single-trit multiplier cell: a*b split into product trit and carry trit.
module ternary_multiplier
  import ternary_pkg::*;
(
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [1:0] prod_c,
  output logic [1:0] carry_c
);

  logic [3:0] m;

  always_comb begin
    m       = 4'(a_i) * 4'(b_i);
    prod_c  = T0;
    carry_c = T0;
    case (m)
      4'd1:    prod_c = T1;
      4'd2:    prod_c = T2;
      4'd4:    begin prod_c = T1; carry_c = T1; end  // 2*2 = 11 base 3
      default: ;
    endcase
  end

endmodule

// File: rtl/ternary_serial_mul.sv
// Sequential N-trit x N-trit unsigned ternary multiplier: one digit pair per
// cycle through a single multiplier cell into a 2N-trit ripple accumulator.
module ternary_serial_mul
  import ternary_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] result,
  output logic           err
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = 4 * N;

  state_e          state_q, state_d;
  logic [2*N-1:0]  a_q, a_d, b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d, result_q, result_d;
  logic [CW-1:0]   i_q, i_d, j_q, j_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic            ops_valid;
  logic [1:0]      cell_p, cell_c;
  logic [CW:0]     pos;
  logic [AW-1:0]   addend, acc_sum;
  logic [2*N:0]    carry;

  // Any invalid trit on either operand rejects the start request.
  always_comb begin
    ops_valid = 1'b1;
    for (int k = 0; k < int'(N); k++) begin
      if (!trit_valid(a[2*k +: 2]) || !trit_valid(b[2*k +: 2])) ops_valid = 1'b0;
    end
  end

  ternary_multiplier u_cell (
    .a_i     (a_q[{j_q, 1'b0} +: 2]),
    .b_i     (b_q[{i_q, 1'b0} +: 2]),
    .prod_c  (cell_p),
    .carry_c (cell_c)
  );

  // Partial product: p at trit i+j, c at trit i+j+1.
  always_comb begin
    pos    = {1'b0, i_q} + {1'b0, j_q};
    addend = AW'({cell_c, cell_p}) << {pos, 1'b0};
  end

  assign carry[0] = 1'b0;

  for (genvar k = 0; k < 2 * N; k++) begin : g_add
    ternary_full_adder u_fa (
      .x_i    (acc_q[2*k +: 2]),
      .y_i    (addend[2*k +: 2]),
      .cin_i  (carry[k]),
      .sum_c  (acc_sum[2*k +: 2]),
      .cout_c (carry[k+1])
    );
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    i_d      = i_q;
    j_d      = j_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!ops_valid) begin
            err_d = 1'b1;
          end else begin
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
            i_d     = '0;
            j_d     = '0;
            err_d   = 1'b0;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        acc_d = acc_sum;
        if (j_q == CW'(N - 1)) begin
          j_d = '0;
          i_d = i_q + CW'(1);
          if (i_q == CW'(N - 1)) begin
            result_d = acc_sum;
            state_d  = DONE;
          end
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MUL);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      j_q      <= j_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ternary_serial_mul.sv
// Directed bench for ternary_serial_mul (N=4) with hand-computed ternary products.
module tb_ternary_serial_mul;

  localparam int unsigned N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [2*N-1:0]  a, b;
  logic            busy, done, err;
  logic [4*N-1:0]  result;

  int n_assert = 0;
  int n_fail   = 0;

  ternary_serial_mul #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: start for one cycle, count done pulses and busy cycles.
  task automatic run(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [15:0] exp, input bit poke);
    int lat, ndone, nbusy;
    lat = 0; ndone = 0; nbusy = 0;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    check({tag, "_err_after_accept"}, 32'(err), 32'd0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
      if (poke) begin
        if (k == 3 || k == 10) begin
          start = 1'b1; a = 8'hAA; b = 8'hAA;
        end else begin
          start = 1'b0;
        end
      end
      if (lat != 0 && k > lat + 2) break;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd16);
    check({tag, "_done_count"}, 32'(ndone), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd15);
    check({tag, "_result"}, 32'(result), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 22_3 * 22_3 = 2101_3 (8*8 = 64)
    run("small", 8'h0A, 8'h0A, 16'h0091, 1'b0);
    // 2222_3 * 2222_3 = 22210001_3 (80*80 = 6400)
    run("max", 8'hAA, 8'hAA, 16'hA901, 1'b0);
    run("zero", 8'h00, 8'hAA, 16'h0000, 1'b0);
    run("one", 8'h01, 8'h01, 16'h0001, 1'b0);

    // Invalid trit 2 in b: rejected, previous result kept.
    @(negedge clk);
    a = 8'h01; b = 8'h30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rej_err", 32'(err), 32'd1);
    check("rej_busy", 32'(busy), 32'd0);
    check("rej_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("rej_busy_later", 32'(busy), 32'd0);
    check("rej_result", 32'(result), 32'h0001);
    run("after_rej", 8'h02, 8'h01, 16'h0002, 1'b0);

    // 0011_3 * 0012_3 = 0202_3 (4*5 = 20); stray starts mid-run ignored.
    run("ignore_start", 8'h05, 8'h06, 16'h0022, 1'b1);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 8'h01, 8'h02, 16'h0002, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
